// File: rtl/alu_issue_unit.sv
// alu_issue_unit: queues ALU requests in a small FIFO, launches one operation
// at a time onto the ALU operand bus, waits LAT cycles for the result, then
// holds the captured result until downstream takes it.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high; valid, once raised, is held together with its
// payload until that edge.
module alu_issue_unit #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  Opin,
    input  logic [31:0] result,
    input  logic        zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic [3:0]  out_op,
    output logic        zero_err,
    output logic [15:0] done_cnt,
    output logic [1:0]  fsm_state
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_OCC = (PW+1)'(DEPTH);
    localparam logic [PW:0]    OCC_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
    localparam logic [3:0]     LAT_CNT  = 4'(LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    state_t        state, state_n;
    logic [3:0]    cnt;
    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ;
    logic          push, fifo_empty;
    logic          issue, capture, handshake;

    assign fsm_state  = state;
    // in_ready depends on registered occupancy only, so a same-edge pop
    // never opens a slot for a push while full.
    assign in_ready   = (occ < FULL_OCC);
    assign fifo_empty = (occ == '0);
    assign push       = in_valid && in_ready;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state decode plus the issue/capture/handshake strobes.
    always_comb begin
        state_n   = state;
        issue     = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    issue   = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    if (!fifo_empty) begin
                        issue   = 1'b1;
                        state_n = WAIT;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Latency counter: loaded at issue, counts down to 1 where capture fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         cnt <= 4'd0;
        else if (issue)                     cnt <= LAT_CNT;
        else if (state == WAIT && cnt != 4'd1) cnt <= cnt - 4'd1;
    end

    // FIFO storage; contents are don't-care while not occupied.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTR_ONE;
            if (issue) rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, issue})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Operand launch, result capture, completion count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A          <= 32'h0;
            B          <= 32'h0;
            Opin       <= 4'h0;
            out_valid  <= 1'b0;
            out_result <= 32'h0;
            out_zero   <= 1'b0;
            out_op     <= 4'h0;
            zero_err   <= 1'b0;
            done_cnt   <= 16'h0;
        end else begin
            if (issue) begin
                A    <= mem[rd_ptr].a;
                B    <= mem[rd_ptr].b;
                Opin <= mem[rd_ptr].op;
            end
            if (capture) begin
                out_valid  <= 1'b1;
                out_result <= result;
                out_zero   <= zero;
                out_op     <= Opin;
                if (zero != (result == 32'h0)) zero_err <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
                done_cnt  <= done_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a combinational ALU model
// (Opin 2 = add, 6 = subtract) and an injectable faulty zero flag.
module tb_alu_issue_unit;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [31:0] dut_a, dut_b;
    logic [3:0]  opin;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [3:0]  out_op;
    logic        zero_err;
    logic [15:0] done_cnt;
    logic [1:0]  fsm_state;
    logic        fault_zero;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic        exp_z_q[$];

    alu_issue_unit #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b),
        .A(dut_a), .B(dut_b), .Opin(opin),
        .result(alu_result), .zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_op(out_op),
        .zero_err(zero_err), .done_cnt(done_cnt), .fsm_state(fsm_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model.
    always_comb begin
        case (opin)
            4'h2:    alu_result = dut_a + dut_b;
            4'h6:    alu_result = dut_a - dut_b;
            default: alu_result = 32'h0;
        endcase
        alu_zero = fault_zero ? 1'b1 : (alu_result == 32'h0);
    end

    // Present one request from a negedge; returns at the negedge after acceptance.
    task automatic push_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", waited);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait at negedges for out_valid, bounded.
    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!out_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_valid_timeout: out_valid 0 after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || zero_err !== 1'b0 || done_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_flags: out_valid=%0b zero_err=%0b done_cnt=%0h want 0/0/0", out_valid, zero_err, done_cnt);
        end
        tests_run++;
        if (dut_a !== 32'h0 || dut_b !== 32'h0 || opin !== 4'h0 || out_result !== 32'h0 || out_op !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_data: A=%0h B=%0h Opin=%0h out_result=%0h out_op=%0h want all 0", dut_a, dut_b, opin, out_result, out_op);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%0b state=%0d want 1/0", in_ready, fsm_state);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        push_op(4'h2, 32'h0000_0005, 32'h0000_0003);
        @(negedge clk);  // issue edge
        tests_run++;
        if (dut_a !== 32'h5 || dut_b !== 32'h3 || opin !== 4'h2 || fsm_state !== 2'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_issue: A=%0h B=%0h Opin=%0h state=%0d valid=%0b want 5/3/2/1/0", dut_a, dut_b, opin, fsm_state, out_valid);
        end
        @(negedge clk);  // issue + 1
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early: out_valid=%0b want 0 one edge after issue", out_valid);
        end
        @(negedge clk);  // issue + 2
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 32'h8 || out_zero !== 1'b0 || out_op !== 4'h2) begin
            tests_failed++;
            $display("FAIL single_result: valid=%0b result=%0h zero=%0b op=%0h want 1/8/0/2", out_valid, out_result, out_zero, out_op);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || done_cnt !== 16'd1 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_done: valid=%0b done_cnt=%0d state=%0d want 0/1/0", out_valid, done_cnt, fsm_state);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        push_op(4'h6, 32'h0000_00AA, 32'h0000_00AA);
        wait_valid(20);
        tests_run++;
        if (out_result !== 32'h0 || out_zero !== 1'b1 || zero_err !== 1'b0 || out_op !== 4'h6) begin
            tests_failed++;
            $display("FAIL zero_result: result=%0h zero=%0b zero_err=%0b op=%0h want 0/1/0/6", out_result, out_zero, zero_err, out_op);
        end
        @(negedge clk);
        tests_run++;
        if (done_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL zero_done: done_cnt=%0d want 2", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        int seen;
        logic stuck;
        out_ready = 1'b0;
        push_op(4'h2, 32'd1, 32'd2);
        push_op(4'h6, 32'd10, 32'd4);
        push_op(4'h2, 32'd100, 32'd23);
        push_op(4'h6, 32'd5, 32'd5);
        push_op(4'h2, 32'hFFFF_FFFF, 32'd2);
        exp_q = '{32'd3, 32'd6, 32'h7B, 32'd0, 32'd1};
        exp_z_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full: in_ready=%0b want 0 with 4 queued", in_ready);
        end
        // A sixth request must be refused while the result is held.
        in_valid = 1'b1; in_op = 4'h2; in_a = 32'd7; in_b = 32'd7;
        stuck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd3) stuck = 1'b0;
        end
        in_valid = 1'b0;
        tests_run++;
        if (stuck !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold: in_ready=%0b valid=%0b result=%0h want 0/1/3 held", in_ready, out_valid, out_result);
        end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            if (out_valid) begin
                tests_run++;
                if (out_result !== exp_q[0] || out_zero !== exp_z_q[0]) begin
                    tests_failed++;
                    $display("FAIL bp_drain_%0d: result=%0h zero=%0b want %0h/%0b", seen, out_result, out_zero, exp_q[0], exp_z_q[0]);
                end
                void'(exp_q.pop_front());
                void'(exp_z_q.pop_front());
                seen++;
            end
            @(negedge clk);
        end
        tests_run++;
        if (seen != 5 || done_cnt !== 16'd7 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_count: results=%0d done_cnt=%0d in_ready=%0b want 5/7/1", seen, done_cnt, in_ready);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || done_cnt !== 16'd7) begin
            tests_failed++;
            $display("FAIL bp_rejected: valid=%0b done_cnt=%0d want 0/7", out_valid, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res_v [3];
        logic [31:0] next_a [3];
        int t [3];
        int k;
        res_v  = '{32'h30, 32'h48, 32'h1234};
        next_a = '{32'h10, 32'h50, 32'h1000};
        out_ready = 1'b1;
        push_op(4'h2, 32'h10, 32'h20);
        push_op(4'h6, 32'h50, 32'h8);
        push_op(4'h2, 32'h1000, 32'h234);
        k = 0;
        for (int i = 0; i < 40 && k < 3; i++) begin
            if (out_valid) begin
                t[k] = cyc;
                tests_run++;
                if (out_result !== res_v[k]) begin
                    tests_failed++;
                    $display("FAIL b2b_result_%0d: result=%0h want %0h", k, out_result, res_v[k]);
                end
                @(negedge clk);
                if (k < 2) begin
                    tests_run++;
                    if (dut_a !== next_a[k+1] || fsm_state !== 2'd1) begin
                        tests_failed++;
                        $display("FAIL b2b_issue_%0d: A=%0h state=%0d want %0h/1", k, dut_a, fsm_state, next_a[k+1]);
                    end
                end
                k++;
            end else begin
                @(negedge clk);
            end
        end
        tests_run++;
        if (k != 3 || (t[1] - t[0]) != LAT + 1 || (t[2] - t[1]) != LAT + 1) begin
            tests_failed++;
            $display("FAIL b2b_spacing: results=%0d gaps=%0d,%0d want 3 and %0d", k, t[1] - t[0], t[2] - t[1], LAT + 1);
        end
    endtask

    task automatic test_zero_err();
        out_ready = 1'b1;
        fault_zero = 1'b1;
        push_op(4'h2, 32'h0, 32'h1);
        wait_valid(20);
        tests_run++;
        if (out_result !== 32'h1 || out_zero !== 1'b1 || zero_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL zerr_set: result=%0h zero=%0b zero_err=%0b want 1/1/1", out_result, out_zero, zero_err);
        end
        fault_zero = 1'b0;
        @(negedge clk);
        push_op(4'h2, 32'd3, 32'd4);
        wait_valid(20);
        tests_run++;
        if (out_result !== 32'd7 || out_zero !== 1'b0 || zero_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL zerr_sticky: result=%0h zero=%0b zero_err=%0b want 7/0/1", out_result, out_zero, zero_err);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic leaked;
        out_ready = 1'b1;
        push_op(4'h2, 32'd9, 32'd9);
        push_op(4'h6, 32'd1, 32'd1);
        tests_run++;
        if (fsm_state !== 2'd1 || dut_a !== 32'd9) begin
            tests_failed++;
            $display("FAIL arst_setup: state=%0d A=%0h want 1/9", fsm_state, dut_a);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (fsm_state !== 2'd0 || out_valid !== 1'b0 || zero_err !== 1'b0 || done_cnt !== 16'h0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_ctrl: state=%0d valid=%0b zero_err=%0b done_cnt=%0d in_ready=%0b want 0/0/0/0/1", fsm_state, out_valid, zero_err, done_cnt, in_ready);
        end
        tests_run++;
        if (dut_a !== 32'h0 || dut_b !== 32'h0 || opin !== 4'h0 || out_result !== 32'h0 || out_op !== 4'h0 || out_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_data: A=%0h B=%0h Opin=%0h result=%0h op=%0h zero=%0b want all 0", dut_a, dut_b, opin, out_result, out_op, out_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || fsm_state !== 2'd0) leaked = 1'b1;
        end
        tests_run++;
        if (leaked !== 1'b0 || dut_a !== 32'h0 || done_cnt !== 16'h0) begin
            tests_failed++;
            $display("FAIL arst_stale: leaked=%0b A=%0h done_cnt=%0d want 0/0/0", leaked, dut_a, done_cnt);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_op = 4'h0; in_a = 32'h0; in_b = 32'h0;
        out_ready = 1'b0; fault_zero = 1'b0;
        test_reset();
        test_single();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_zero_err();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
